sram_req_sequencer: RTL

Request sequencer sitting directly upstream of the 32x128 single-port SRAM macro (1 RW port, active-low chip/write enables, inputs registered on rising clk0, array access on falling clk0). Converts a valid/ready request stream into correctly timed macro commands. Captures read data into a response FIFO with valid/ready backpressure. Uses credit-based flow control so no read response is ever dropped.

---
 rtl/sram_req_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sram_req_sequencer.sv
// Request sequencer in front of a single-port SRAM macro (registered inputs on
// rising clk0, array access on falling clk0). Turns a request stream into macro
// commands, tracks outstanding reads and buffers read data in a response FIFO.
// Reads are only accepted while a FIFO slot is guaranteed, so no response is lost.
//
// Handshakes: a transfer happens on a rising clk0 edge where valid && ready are
// both high; valid never depends on ready, and the producer holds its payload
// stable while valid is high and ready is low.
module sram_req_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam logic [PW+1:0] DEPTH_L = RSP_DEPTH[PW+1:0];
  localparam logic [PW:0]   PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic                  csb0_q, csb0_d;
  logic                  web0_q, web0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;
  logic [1:0]            p_q, p_d;
  logic [PW:0]           wr_ptr_q, wr_ptr_d;
  logic [PW:0]           rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [RSP_DEPTH];
  logic [15:0]           rd_count_q, rd_count_d;
  logic [15:0]           wr_count_q, wr_count_d;

  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  empty;
  logic [PW:0]           fifo_count;
  logic [PW+1:0]         inflight;
  logic [PW+1:0]         credit_used;

  // Credit check: every queued entry and every read still in the macro pipe
  // owns a FIFO slot; a new request is taken only if one slot is still free.
  always_comb begin
    fifo_count  = wr_ptr_q - rd_ptr_q;
    inflight    = {{PW{1'b0}}, p_q[1] & p_q[0], p_q[1] ^ p_q[0]};
    credit_used = {1'b0, fifo_count} + inflight;
    req_ready   = !rst0 && (credit_used < DEPTH_L);
    accept      = req_valid && req_ready;
    empty       = (wr_ptr_q == rd_ptr_q);
    rsp_valid   = !empty;
    rsp_rdata   = mem_q[rd_ptr_q[PW-1:0]];
    push        = p_q[1];
    pop         = rsp_valid && rsp_ready;
  end

  // Next macro command, read-tracking pipe and request counters.
  always_comb begin
    csb0_d     = 1'b1;
    web0_d     = web0_q;
    addr0_d    = addr0_q;
    din0_d     = din0_q;
    p_d        = {p_q[0], 1'b0};
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (accept) begin
      csb0_d  = 1'b0;
      web0_d  = ~req_we;
      addr0_d = req_addr;
      if (req_we) begin
        din0_d     = req_wdata;
        wr_count_d = wr_count_q + 16'd1;
      end else begin
        p_d[0]     = 1'b1;
        rd_count_d = rd_count_q + 16'd1;
      end
    end
  end

  // Response FIFO pointer and storage updates; macro data lands two edges after accept.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[PW-1:0]] = dout0;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Control state; reset drops in-flight reads and idles the macro pins.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      csb0_q     <= 1'b1;
      web0_q     <= 1'b1;
      addr0_q    <= '0;
      din0_q     <= '0;
      p_q        <= 2'b00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_count_q <= 16'd0;
      wr_count_q <= 16'd0;
    end else begin
      csb0_q     <= csb0_d;
      web0_q     <= web0_d;
      addr0_q    <= addr0_d;
      din0_q     <= din0_d;
      p_q        <= p_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  // FIFO data array; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk0) begin
    mem_q <= mem_d;
  end

  assign csb0     = csb0_q;
  assign web0     = web0_q;
  assign addr0    = addr0_q;
  assign din0     = din0_q;
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

endmodule
